// File: rtl/input_conditioner_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// input_conditioner_pkg : shared widths for the input conditioner and processor
// Rev 1.0
// ---------------------------------------------------------------------------
package input_conditioner_pkg;

  localparam int c_DEFAULT_BIT_WIDTH       = 4;
  localparam int c_DEFAULT_DEBOUNCE_CYCLES = 16;

  // Counter must hold 0..DEBOUNCE_CYCLES-1; one extra state keeps width >= 1 for D=1.
  function automatic int cnt_width(input int debounce_cycles);
    return $clog2(debounce_cycles + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/input_conditioner_debounce_bit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// debounce_bit : 2-flop synchronizer plus stable-count debouncer for one signal
// Rev 1.0
// ---------------------------------------------------------------------------
module debounce_bit
  import input_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = c_DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic i_raw,
  output logic o_q,
  output logic o_accept
);

  localparam int             c_CW   = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [c_CW-1:0] c_LAST = c_CW'(DEBOUNCE_CYCLES - 1);

  logic            r_meta;
  logic            r_sync;
  logic            r_q;
  logic [c_CW-1:0] r_cnt;
  logic            w_mismatch;
  logic            w_accept;

  assign w_mismatch = r_sync ^ r_q;
  assign w_accept   = w_mismatch && (r_cnt == c_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
      r_q    <= 1'b0;
      r_cnt  <= '0;
    end else begin
      r_meta <= i_raw;
      r_sync <= r_meta;
      if (!w_mismatch) begin
        r_cnt <= '0;
      end else if (w_accept) begin
        r_q   <= r_sync;
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_q      = r_q;
  assign o_accept = w_accept;

endmodule
`default_nettype wire

// File: rtl/input_conditioner.sv
`default_nettype none
// ---------------------------------------------------------------------------
// input_conditioner : debounces user switches; INPUT_COND_CHANGE_PULSE_EN adds in_changed
// Rev 1.0
// ---------------------------------------------------------------------------
module input_conditioner
  import input_conditioner_pkg::*;
#(
  parameter int BIT_WIDTH       = c_DEFAULT_BIT_WIDTH,
  parameter int DEBOUNCE_CYCLES = c_DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [BIT_WIDTH-2:0] raw_in,
  input  logic                 raw_sel_usr,
  output logic [BIT_WIDTH-2:0] in,
`ifdef INPUT_COND_CHANGE_PULSE_EN
  output logic                 sel_usr,
  output logic                 in_changed
`else
  output logic                 sel_usr
`endif
);

  logic [BIT_WIDTH-1:0] w_raw;
  logic [BIT_WIDTH-1:0] w_q;
  logic [BIT_WIDTH-1:0] w_accept;

  assign w_raw = {raw_sel_usr, raw_in};

  generate
    for (genvar i = 0; i < BIT_WIDTH; i++) begin : g_bit
      debounce_bit #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_debounce_bit (
        .clk     (clk),
        .rst     (rst),
        .i_raw   (w_raw[i]),
        .o_q     (w_q[i]),
        .o_accept(w_accept[i])
      );
    end
  endgenerate

  assign in      = w_q[BIT_WIDTH-2:0];
  assign sel_usr = w_q[BIT_WIDTH-1];

`ifdef INPUT_COND_CHANGE_PULSE_EN
  logic r_in_changed;

  // Accept strobes fire on the edge that updates q, so the pulse lands in the cycle after.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_in_changed <= 1'b0;
    end else begin
      r_in_changed <= |w_accept;
    end
  end

  assign in_changed = r_in_changed;
`else
  logic w_unused_accept;
  assign w_unused_accept = ^w_accept;
`endif

endmodule
`default_nettype wire

// File: doc/input_conditioner.md
INPUT_CONDITIONER -- requirements
Module: input_conditioner

Interface
REQ-001 Parameter: BIT_WIDTH, default 4, datapath width of the processor; user-input width is BIT_WIDTH-1.
REQ-002 Parameter: DEBOUNCE_CYCLES, default 16, consecutive stable synchronized cycles required to accept a new level; legal range >=1.
REQ-003 Port: clk  input  1  sole clock, all state updates on rising edge.
REQ-004 Port: rst  input  1  reset, synchronous, active-high.
REQ-005 Port: raw_in  input  BIT_WIDTH-1  asynchronous user switch inputs.
REQ-006 Port: raw_sel_usr  input  1  asynchronous user/immediate select switch.
REQ-007 Port: in  output  BIT_WIDTH-1  debounced user data, drives processor top-level in.
REQ-008 Port: sel_usr  output  1  debounced select, drives processor top-level sel_usr.
REQ-009 Port: in_changed  output  1  one-cycle strobe on any accepted change; present only under REQ-025.

Function
REQ-010 Each of the BIT_WIDTH signals (raw_in bits plus raw_sel_usr) SHALL pass through an independent 2-flop synchronizer, then an independent debouncer.
REQ-011 Debouncer state: stable level q, counter cnt of width clog2(DEBOUNCE_CYCLES+1); outputs in/sel_usr SHALL be q directly (registered, no combinational path from raw inputs).
REQ-012 When synchronized value equals q, cnt SHALL be cleared to 0 that edge.
REQ-013 When synchronized value differs from q and cnt < DEBOUNCE_CYCLES-1, cnt SHALL increment by 1.
REQ-014 When synchronized value differs from q and cnt == DEBOUNCE_CYCLES-1, q SHALL take the synchronized value and cnt SHALL clear to 0.
REQ-015 Latency: raw level changing before edge k and held SHALL appear on the output after edge k+1+DEBOUNCE_CYCLES.
REQ-016 Glitch: a synchronized mismatch lasting fewer than DEBOUNCE_CYCLES cycles SHALL leave q unchanged and return cnt to 0.
REQ-017 Counter SHALL never wrap; cnt SHALL never exceed DEBOUNCE_CYCLES-1.
REQ-018 Bits are independent: different bits SHALL each accept changes on their own schedules; simultaneous acceptances in one cycle are legal.
REQ-019 in_changed SHALL be high for exactly the one cycle following an edge at which any q bit changed; several bits changing at the same edge SHALL produce one single-cycle pulse; changes on consecutive edges SHALL produce consecutive-cycle assertion.

Reset
REQ-020 While rst is high at an edge: synchronizer flops, all q, all cnt and in_changed SHALL be 0.
REQ-021 Reset after the first edge SHALL abort any in-progress count; the first post-reset cycle restarts from REQ-012/013.
REQ-022 After reset release with raw inputs held high, outputs SHALL rise after edge 1+DEBOUNCE_CYCLES counted from the first non-reset edge, with in_changed pulsing once.

Configuration
REQ-023 Macro INPUT_COND_CHANGE_PULSE_EN selects the change strobe.
REQ-024 Without INPUT_COND_CHANGE_PULSE_EN: port in_changed and its register SHALL be absent; all other behaviour identical.
REQ-025 With INPUT_COND_CHANGE_PULSE_EN: in_changed present and behaves per REQ-019/020.

Structure
REQ-026 Shared package/header SHALL hold default BIT_WIDTH and DEBOUNCE_CYCLES constants used by this block and the processor top.
REQ-027 Sub-module debounce_bit (synchronizer + counter + q for one signal, parameter DEBOUNCE_CYCLES) SHALL be instantiated BIT_WIDTH times via generate.
REQ-028 Top-level integration: in and sel_usr SHALL connect directly to the processor's in and sel_usr; no further registering.

Verification (BIT_WIDTH=4, DEBOUNCE_CYCLES=4)
REQ-029 Reset: rst high 3 cycles, raw_in=3'b111 -> in=0, sel_usr=0, in_changed=0 throughout reset.
REQ-030 Clean step: raw_in 000->101 before edge 0, held -> in=101 after edge 5, in_changed=1 only the following cycle.
REQ-031 Glitch: raw_sel_usr high for 3 cycles then low -> sel_usr stays 0, in_changed never asserts.
REQ-032 Bounce: raw_in[0] toggles 1,0,1 each cycle then holds 1 -> in[0] rises exactly 5 edges after the final transition.
REQ-033 Simultaneous: raw_in=111 and raw_sel_usr=1 in the same cycle -> all outputs change at the same edge, exactly one in_changed pulse.
REQ-034 Reset mid-count: raw_in[1] high 3 cycles, rst pulsed 1 cycle, raw held -> in[1] rises after edge 5 counted from the first non-reset edge; build without INPUT_COND_CHANGE_PULSE_EN also passes REQ-029..033 minus in_changed checks.
